spi_master_arbiter: RTL and testbench

SPI master controller that shares one SPI bus (SCL, CS_n, MOSI, MISO) between NUM_REQ on-chip requesters.
- Arbitrates requests round-robin and latches the winner's tx_data and mode.
- Sequences one 8-bit full-duplex frame MSB-first in any of the 4 SPI modes.
- Returns the received byte to the granted requester with a single-cycle done pulse.
- Sits between the host-side requesters and the SPI slave pins.

---
 rtl/spi_master_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// Round-robin arbitrated SPI master: NUM_REQ requesters share one SPI bus.
// Each grant runs one 8-bit MSB-first full-duplex frame in the winner's SPI mode.
module spi_master_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_tx_data,
  input  logic [2*NUM_REQ-1:0]       req_mode,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       done,
  output logic [$clog2(NUM_REQ)-1:0] done_id,
  output logic [7:0]                 rx_data,
  output logic                       busy,
  output logic                       SCL,
  output logic                       CS_n,
  output logic                       MOSI,
  input  logic                       MISO
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned DW  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  if (CLK_DIV < 2) begin : g_div_check
    $error("spi_master_arbiter: CLK_DIV must be at least 2");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_req_check
    $error("spi_master_arbiter: NUM_REQ must be in 2..8");
  end

  logic [2:0]         state, state_n;
  logic [DW-1:0]      div_cnt, div_n;
  logic [4:0]         edge_cnt, edge_n;
  logic [7:0]         tx_sr, tx_n;
  logic [7:0]         rx_sr, rx_n;
  logic [1:0]         mode, mode_n;
  logic [IDW-1:0]     ptr, ptr_n;
  logic [IDW-1:0]     owner, owner_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic               done_n, busy_n, scl_n, cs_n_n, mosi_n;
  logic [IDW-1:0]     done_id_n;
  logic [7:0]         rx_data_n;

  logic               found;
  logic [IDW-1:0]     winner;
  logic [7:0]         win_data;
  logic [1:0]         win_mode;
  int unsigned        k;
  logic               div_last, do_edge, sample;

  // Round-robin search: first requester at or after ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_data = '0;
    win_mode = '0;
    k        = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && req[k]) begin
        found    = 1'b1;
        winner   = IDW'(k);
        win_data = req_tx_data[8*k +: 8];
        win_mode = req_mode[2*k +: 2];
      end
    end
  end

  always_comb begin
    state_n   = state;
    div_n     = div_cnt;
    edge_n    = edge_cnt;
    tx_n      = tx_sr;
    rx_n      = rx_sr;
    mode_n    = mode;
    ptr_n     = ptr;
    owner_n   = owner;
    gnt_n     = '0;
    done_n    = 1'b0;
    done_id_n = done_id;
    rx_data_n = rx_data;
    busy_n    = busy;
    scl_n     = SCL;
    cs_n_n    = CS_n;
    mosi_n    = MOSI;
    do_edge   = 1'b0;
    sample    = 1'b0;
    div_last  = (div_cnt == DIV_LAST);

    case (state)
      S_IDLE: begin
        scl_n = mode[1];
        if (found) begin
          state_n        = S_SETUP;
          div_n          = '0;
          edge_n         = '0;
          gnt_n[winner]  = 1'b1;
          tx_n           = win_data;
          mode_n         = win_mode;
          owner_n        = winner;
          ptr_n          = (32'(winner) == NUM_REQ - 1) ? '0 : winner + IDW'(1);
          cs_n_n         = 1'b0;
          busy_n         = 1'b1;
          scl_n          = win_mode[1];
          if (!win_mode[0]) mosi_n = win_data[7];
        end
      end
      S_SETUP: begin
        div_n = div_cnt + DW'(1);
        if (div_last) begin
          state_n = S_XFER;
          div_n   = '0;
          edge_n  = 5'd1;
          do_edge = 1'b1;
        end
      end
      S_XFER: begin
        div_n = div_cnt + DW'(1);
        if (div_last) begin
          div_n = '0;
          if (edge_cnt == 5'd16) begin
            state_n = S_HOLD;
          end else begin
            edge_n  = edge_cnt + 5'd1;
            do_edge = 1'b1;
          end
        end
      end
      S_HOLD: begin
        div_n = div_cnt + DW'(1);
        if (div_last) begin
          state_n   = S_GAP;
          div_n     = '0;
          cs_n_n    = 1'b1;
          done_n    = 1'b1;
          rx_data_n = rx_sr;
          done_id_n = owner;
        end
      end
      S_GAP: begin
        div_n = div_cnt + DW'(1);
        if (div_last) begin
          state_n = S_IDLE;
          div_n   = '0;
          busy_n  = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Odd edges lead; the sampling edge is leading for CPHA=0, trailing for CPHA=1.
    if (do_edge) begin
      scl_n  = ~SCL;
      sample = edge_n[0] ^ mode[0];
      if (sample) begin
        rx_n = {rx_sr[6:0], MISO};
      end else if (mode[0]) begin
        mosi_n = tx_sr[7];
        tx_n   = {tx_sr[6:0], 1'b0};
      end else if (edge_n != 5'd16) begin
        mosi_n = tx_sr[6];
        tx_n   = {tx_sr[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      mode     <= 2'b00;
      ptr      <= '0;
      owner    <= '0;
      gnt      <= '0;
      done     <= 1'b0;
      done_id  <= '0;
      rx_data  <= 8'h00;
      busy     <= 1'b0;
      SCL      <= 1'b0;
      CS_n     <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      edge_cnt <= edge_n;
      tx_sr    <= tx_n;
      rx_sr    <= rx_n;
      mode     <= mode_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      gnt      <= gnt_n;
      done     <= done_n;
      done_id  <= done_id_n;
      rx_data  <= rx_data_n;
      busy     <= busy_n;
      SCL      <= scl_n;
      CS_n     <= cs_n_n;
      MOSI     <= mosi_n;
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: timeline model of each frame plus an SPI slave.
module tb_spi_master_arbiter;

  localparam int NR  = 2;
  localparam int CD  = 4;
  localparam int IDW = $clog2(NR);

  logic            clk, rst;
  logic [NR-1:0]   req;
  logic [8*NR-1:0] req_tx_data;
  logic [2*NR-1:0] req_mode;
  logic [NR-1:0]   gnt;
  logic            done;
  logic [IDW-1:0]  done_id;
  logic [7:0]      rx_data;
  logic            busy, SCL, CS_n, MOSI, miso;

  logic            loopback;
  logic [7:0]      slave_byte;
  logic [1:0]      slave_mode;

  spi_master_arbiter #(.NUM_REQ(NR), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .req(req), .req_tx_data(req_tx_data), .req_mode(req_mode),
    .gnt(gnt), .done(done), .done_id(done_id), .rx_data(rx_data), .busy(busy),
    .SCL(SCL), .CS_n(CS_n), .MOSI(MOSI), .MISO(miso)
  );

  int n_cmp, n_bad, cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin @(posedge clk); cyc++; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // SPI slave: shifts slave_byte out and captures MOSI on the edges the mode dictates.
  logic       sl_miso, sl_last, sl_lead;
  logic [7:0] sl_tx, sl_rx;
  bit         sl_active;
  int         sl_edges, sl_idx;

  assign miso = loopback ? MOSI : sl_miso;

  initial begin
    sl_miso = 1'b0; sl_rx = 8'h00; sl_tx = 8'h00; sl_active = 1'b0;
    sl_last = 1'b0; sl_edges = 0; sl_idx = 7; sl_lead = 1'b0;
    forever begin
      @(SCL or CS_n);
      #1;
      if (CS_n === 1'b1) begin
        sl_active = 1'b0;
      end else if (CS_n === 1'b0 && !sl_active) begin
        sl_active = 1'b1; sl_edges = 0; sl_idx = 7;
        sl_tx = slave_byte; sl_last = slave_mode[1];
        if (!slave_mode[0]) sl_miso = sl_tx[7];
      end
      if (sl_active && SCL !== sl_last) begin
        sl_last = SCL;
        sl_edges++;
        sl_lead = sl_edges[0];
        if (sl_lead ^ slave_mode[0]) begin
          sl_rx = {sl_rx[6:0], MOSI};
        end else if (slave_mode[0]) begin
          if (sl_idx >= 0) begin sl_miso = sl_tx[sl_idx]; sl_idx--; end
        end else if (sl_idx > 0) begin
          sl_idx--; sl_miso = sl_tx[sl_idx];
        end
      end
    end
  end

  // Model: each frame is a fixed timeline measured in cycles from its grant.
  int         m_d, m_ptr, m_owner, m_w, m_k, m_edges;
  logic [7:0] m_data, m_rxf;
  logic [1:0] m_mode;
  logic [NR-1:0]  e_gnt;
  logic           e_done, e_busy, e_scl, e_cs, e_mosi;
  logic [7:0]     e_rx;
  logic [IDW-1:0] e_id;

  initial begin
    m_d = -1; m_ptr = 0; m_owner = 0; m_w = 0; m_k = 0; m_edges = 0;
    m_data = 8'h00; m_rxf = 8'h00; m_mode = 2'b00;
    e_gnt = '0; e_done = 1'b0; e_busy = 1'b0; e_scl = 1'b0; e_cs = 1'b1; e_mosi = 1'b0;
    e_rx = 8'h00; e_id = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_d = -1; m_ptr = 0; m_owner = 0; m_mode = 2'b00;
        e_rx = 8'h00; e_id = '0; e_mosi = 1'b0;
      end else if (m_d >= 0) begin
        m_d++;
        if (m_d == 19*CD) m_d = -1;
      end else if (req != '0) begin
        m_w = -1;
        for (int i = 0; i < NR; i++) begin
          m_k = (m_ptr + i) % NR;
          if (m_w < 0 && req[m_k]) m_w = m_k;
        end
        m_d = 0; m_owner = m_w;
        m_data = req_tx_data[8*m_w +: 8];
        m_mode = req_mode[2*m_w +: 2];
        m_rxf  = loopback ? m_data : slave_byte;
        m_ptr  = (m_w + 1) % NR;
      end
      e_gnt = '0; e_done = 1'b0;
      if (m_d < 0) begin
        e_cs = 1'b1; e_busy = 1'b0; e_scl = m_mode[1];
      end else begin
        m_edges = (m_d < CD) ? 0 : imin(m_d / CD, 16);
        e_cs   = (m_d >= 18*CD);
        e_busy = 1'b1;
        e_scl  = m_mode[1] ^ m_edges[0];
        if (m_d == 0) e_gnt[m_owner] = 1'b1;
        if (m_d == 18*CD) begin e_done = 1'b1; e_rx = m_rxf; e_id = IDW'(m_owner); end
        if (!m_mode[0]) e_mosi = m_data[7 - imin(m_edges / 2, 7)];
        else if (m_edges > 0) e_mosi = m_data[8 - imin((m_edges + 1) / 2, 8)];
      end
    end
  end

  // Per-cycle comparison plus event logs for the directed checks.
  int         g_id[$], g_cyc[$], d_cyc[$];
  logic [7:0] d_rx[$];
  int         cs_cnt, cs_low_len;

  initial begin
    cs_cnt = 0; cs_low_len = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("done", 32'(done), 32'(e_done));
        chk("done_id", 32'(done_id), 32'(e_id));
        chk("rx_data", 32'(rx_data), 32'(e_rx));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("SCL", 32'(SCL), 32'(e_scl));
        chk("CS_n", 32'(CS_n), 32'(e_cs));
        chk("MOSI", 32'(MOSI), 32'(e_mosi));
      end
      for (int i = 0; i < NR; i++) if (gnt[i]) begin g_id.push_back(i); g_cyc.push_back(cyc); end
      if (done) begin d_cyc.push_back(cyc); d_rx.push_back(rx_data); end
      if (CS_n === 1'b0) cs_cnt++;
      else if (cs_cnt != 0) begin cs_low_len = cs_cnt; cs_cnt = 0; end
    end
  end

  task automatic run_frame(input int id, input logic [7:0] data, input logic [1:0] mode,
                           input logic [7:0] sbyte, input bit lb, input logic [7:0] exp_rx);
    int n;
    @(negedge clk);
    req_tx_data[8*id +: 8] = data;
    req_mode[2*id +: 2]    = mode;
    slave_byte = sbyte; slave_mode = mode; loopback = lb;
    req[id] = 1'b1;
    n = 0;
    while (gnt[id] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("frame_gnt", 32'(gnt[id]), 32'd1);
    req[id] = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("frame_done", 32'(done), 32'd1);
    chk("frame_rx", 32'(rx_data), 32'(exp_rx));
    chk("frame_id", 32'(done_id), 32'(id));
    chk("slave_saw_mosi", 32'(sl_rx), 32'(data));
    @(negedge clk);
    chk("cs_low_len", 32'(cs_low_len), 32'(18*CD));
    chk("scl_idle", 32'(SCL), 32'(mode[1]));
  endtask

  initial begin
    int n;
    n_cmp = 0; n_bad = 0;
    req = '0; req_tx_data = '0; req_mode = '0;
    loopback = 1'b0; slave_byte = 8'h00; slave_mode = 2'b00;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_CS_n", 32'(CS_n), 32'd1);
    chk("rst_SCL", 32'(SCL), 32'd0);
    chk("rst_MOSI", 32'(MOSI), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx", 32'(rx_data), 32'h00);
    chk("rst_id", 32'(done_id), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Modes 0 and 3 against a driving slave, then modes 1 and 2 in loopback.
    run_frame(0, 8'hA5, 2'b00, 8'h3C, 1'b0, 8'h3C);
    run_frame(1, 8'h81, 2'b11, 8'hF0, 1'b0, 8'hF0);
    run_frame(0, 8'h5A, 2'b01, 8'h00, 1'b1, 8'h5A);
    run_frame(1, 8'h5A, 2'b10, 8'h00, 1'b1, 8'h5A);

    // Reset after the fourth SCL edge aborts the frame.
    @(negedge clk);
    loopback = 1'b0; slave_byte = 8'h5E; slave_mode = 2'b00;
    req_tx_data[7:0] = 8'hE7; req_mode[1:0] = 2'b00; req[0] = 1'b1;
    n = 0;
    while (gnt[0] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("t5_gnt", 32'(gnt[0]), 32'd1);
    req[0] = 1'b0;
    repeat (18) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_CS_n", 32'(CS_n), 32'd1);
    chk("t5_SCL", 32'(SCL), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_rx", 32'(rx_data), 32'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_frame(1, 8'h33, 2'b00, 8'hC9, 1'b0, 8'hC9);

    // Both requesters held from reset: alternating grants.
    @(negedge clk);
    rst = 1'b1;
    loopback = 1'b1;
    req_tx_data = {8'h22, 8'h11}; req_mode = '0; req = '1;
    g_id.delete(); g_cyc.delete(); d_cyc.delete(); d_rx.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (g_id.size() < 4 && n < 1000) begin @(negedge clk); n++; end
    req = '0;
    chk("t4_grants", 32'(g_id.size()), 32'd4);
    n = 0;
    while (d_cyc.size() < 4 && n < 200) begin @(negedge clk); n++; end
    chk("t4_dones", 32'(d_cyc.size()), 32'd4);
    if (g_id.size() >= 4 && d_cyc.size() >= 4) begin
      chk("t4_order0", 32'(g_id[0]), 32'd0);
      chk("t4_order1", 32'(g_id[1]), 32'd1);
      chk("t4_order2", 32'(g_id[2]), 32'd0);
      chk("t4_order3", 32'(g_id[3]), 32'd1);
      chk("t4_period", 32'(g_cyc[1] - g_cyc[0]), 32'(19*CD + 1));
      chk("t4_cs_high", 32'(g_cyc[1] - d_cyc[0]), 32'd5);
      chk("t4_rx0", 32'(d_rx[0]), 32'h11);
      chk("t4_rx1", 32'(d_rx[1]), 32'h22);
    end

    // Request arriving mid-frame waits; mid-frame data/mode changes are ignored.
    repeat (8) @(negedge clk);
    g_id.delete(); g_cyc.delete(); d_cyc.delete(); d_rx.delete();
    loopback = 1'b1;
    req_tx_data[7:0] = 8'hC6; req_mode[1:0] = 2'b00; req[0] = 1'b1;
    n = 0;
    while (g_id.size() < 1 && n < 200) begin @(negedge clk); n++; end
    req[0] = 1'b0;
    repeat (10) @(negedge clk);
    req_tx_data[15:8] = 8'h9D; req_mode[3:2] = 2'b01; req[1] = 1'b1;
    repeat (5) @(negedge clk);
    req_tx_data[7:0] = 8'hFF; req_mode[1:0] = 2'b11;
    n = 0;
    while (g_id.size() < 2 && n < 200) begin @(negedge clk); n++; end
    req[1] = 1'b0;
    chk("t6_grants", 32'(g_id.size()), 32'd2);
    n = 0;
    while (d_cyc.size() < 2 && n < 200) begin @(negedge clk); n++; end
    chk("t6_dones", 32'(d_cyc.size()), 32'd2);
    if (g_id.size() >= 2 && d_rx.size() >= 2) begin
      chk("t6_second_id", 32'(g_id[1]), 32'd1);
      chk("t6_period", 32'(g_cyc[1] - g_cyc[0]), 32'(19*CD + 1));
      chk("t6_rx0", 32'(d_rx[0]), 32'hC6);
      chk("t6_rx1", 32'(d_rx[1]), 32'h9D);
    end

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
